// File: rtl/wave_capture.sv
`default_nettype none
// ============================================================================
// wave_capture : arms on a positive zero crossing, captures 256 samples into
//                the hidden half of a double-buffered 512x8 waveform RAM.
// Revision     : 1.0
// ============================================================================
module wave_capture #(
   parameter int DECIMATION   = 1,
   parameter int TRIG_TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        new_sample_ready,
   input  logic [15:0] new_sample_in,
   input  logic        wave_display_idle,
   output logic [8:0]  write_address,
   output logic        write_enable,
   output logic [7:0]  write_sample,
   output logic        read_index
);

   localparam int TW = $clog2(TRIG_TIMEOUT) + 1;

   typedef enum logic [1:0] {
      ST_ARMED  = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_WAIT   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            ri_q, ri_d;
   logic [7:0]      count_q, count_d;
   logic [7:0]      decim_q, decim_d;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic [15:0]     prev_q, prev_d;
   logic            we_q, we_d;
   logic [8:0]      waddr_q, waddr_d;
   logic [7:0]      wdata_q, wdata_d;

   logic            w_crossing;
   logic [7:0]      w_code;

   assign w_crossing = new_sample_ready & prev_q[15] & ~new_sample_in[15];
   // Offset-binary top byte, inverted so positive samples draw upward.
   assign w_code     = 8'd255 - {~new_sample_in[15], new_sample_in[14:8]};

   always_comb begin
      state_d = state_q;
      ri_d    = ri_q;
      count_d = count_q;
      decim_d = decim_q;
      tcnt_d  = tcnt_q;
      prev_d  = prev_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;

      if (new_sample_ready) begin
         prev_d = new_sample_in;
      end

      case (state_q)
         ST_ARMED: begin
            if (new_sample_ready) begin
               if (w_crossing || (tcnt_q == TW'(TRIG_TIMEOUT - 1))) begin
                  we_d    = 1'b1;
                  waddr_d = {~ri_q, 8'd0};
                  wdata_d = w_code;
                  count_d = 8'd1;
                  decim_d = 8'd0;
                  tcnt_d  = '0;
                  state_d = ST_ACTIVE;
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
         end
         ST_ACTIVE: begin
            if (new_sample_ready) begin
               if (decim_q == 8'(DECIMATION - 1)) begin
                  we_d    = 1'b1;
                  waddr_d = {~ri_q, count_q};
                  wdata_d = w_code;
                  count_d = count_q + 8'd1;
                  decim_d = 8'd0;
                  if (count_q == 8'hFF) begin
                     state_d = ST_WAIT;
                  end
               end else begin
                  decim_d = decim_q + 8'd1;
               end
            end
         end
         ST_WAIT: begin
            // The swap takes effect next cycle; a strobe here only refreshes prev.
            if (wave_display_idle) begin
               ri_d    = ~ri_q;
               count_d = 8'd0;
               tcnt_d  = '0;
               waddr_d = {ri_q, 8'd0};
               state_d = ST_ARMED;
            end
         end
         default: begin
            state_d = ST_ARMED;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_ARMED;
         ri_q    <= 1'b0;
         count_q <= 8'd0;
         decim_q <= 8'd0;
         tcnt_q  <= '0;
         prev_q  <= 16'd0;
         we_q    <= 1'b0;
         waddr_q <= 9'h100;
         wdata_q <= 8'd0;
      end else begin
         state_q <= state_d;
         ri_q    <= ri_d;
         count_q <= count_d;
         decim_q <= decim_d;
         tcnt_q  <= tcnt_d;
         prev_q  <= prev_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   assign write_address = waddr_q;
   assign write_enable  = we_q;
   assign write_sample  = wdata_q;
   assign read_index    = ri_q;

endmodule
`default_nettype wire

// File: tb/tb_wave_capture.sv
`default_nettype none
// ============================================================================
// tb_wave_capture : scoreboard bench for wave_capture at DECIMATION 1 and 4.
// Revision        : 1.0
// ============================================================================
module tb_wave_capture;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        new_sample_ready = 1'b0;
   logic [15:0] new_sample_in = 16'd0;
   logic        wave_display_idle = 1'b0;

   logic [8:0]  wa1, wa4;
   logic        we1, we4;
   logic [7:0]  ws1, ws4;
   logic        ri1, ri4;

   always #5 clk = ~clk;

   wave_capture #(.DECIMATION(1), .TRIG_TIMEOUT(1024)) u_dut1 (
      .clk               (clk),
      .reset             (reset),
      .new_sample_ready  (new_sample_ready),
      .new_sample_in     (new_sample_in),
      .wave_display_idle (wave_display_idle),
      .write_address     (wa1),
      .write_enable      (we1),
      .write_sample      (ws1),
      .read_index        (ri1)
   );

   wave_capture #(.DECIMATION(4), .TRIG_TIMEOUT(1024)) u_dut4 (
      .clk               (clk),
      .reset             (reset),
      .new_sample_ready  (new_sample_ready),
      .new_sample_in     (new_sample_in),
      .wave_display_idle (wave_display_idle),
      .write_address     (wa4),
      .write_enable      (we4),
      .write_sample      (ws4),
      .read_index        (ri4)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model, one slot per instance: index 0 -> DECIMATION 1, 1 -> DECIMATION 4
   localparam int M_ARMED = 0, M_ACTIVE = 1, M_WAIT = 2;
   int          dec_of [2] = '{1, 4};
   int          m_st   [2] = '{0, 0};
   logic        m_ri   [2] = '{1'b0, 1'b0};
   int          m_cnt  [2] = '{0, 0};
   int          m_dec  [2] = '{0, 0};
   int          m_tc   [2] = '{0, 0};
   logic [15:0] m_prev [2] = '{16'd0, 16'd0};
   logic [16:0] sb1[$];
   logic [16:0] sb4[$];

   function automatic logic [7:0] conv(input logic [15:0] s);
      logic [7:0] off;
      off  = {~s[15], s[14:8]};
      conv = 8'd255 - off;
   endfunction

   task automatic push_exp(input int k, input logic [8:0] a, input logic [7:0] d);
      if (k == 0) sb1.push_back({a, d});
      else        sb4.push_back({a, d});
   endtask

   task automatic model_step(input int k, input logic rs, input logic rd,
                             input logic [15:0] s, input logic id);
      if (rs) begin
         m_st[k] = M_ARMED; m_ri[k] = 1'b0; m_cnt[k] = 0;
         m_dec[k] = 0; m_tc[k] = 0; m_prev[k] = 16'd0;
         return;
      end
      if (m_st[k] == M_WAIT) begin
         if (id) begin
            m_ri[k] = ~m_ri[k]; m_cnt[k] = 0; m_tc[k] = 0; m_st[k] = M_ARMED;
         end
      end else if (rd) begin
         if (m_st[k] == M_ARMED) begin
            if ((m_prev[k][15] && !s[15]) || m_tc[k] == 1023) begin
               push_exp(k, {~m_ri[k], 8'd0}, conv(s));
               m_cnt[k] = 1; m_dec[k] = 0; m_tc[k] = 0; m_st[k] = M_ACTIVE;
            end else begin
               m_tc[k]++;
            end
         end else begin
            if (m_dec[k] == dec_of[k] - 1) begin
               push_exp(k, {~m_ri[k], 8'(m_cnt[k])}, conv(s));
               m_dec[k] = 0;
               if (m_cnt[k] == 255) begin
                  m_cnt[k] = 0; m_st[k] = M_WAIT;
               end else begin
                  m_cnt[k]++;
               end
            end else begin
               m_dec[k]++;
            end
         end
      end
      if (rd) m_prev[k] = s;
   endtask

   task automatic tick(input logic rs, input logic rd, input logic [15:0] s, input logic id);
      @(negedge clk);
      reset = rs; new_sample_ready = rd; new_sample_in = s; wave_display_idle = id;
      for (int k = 0; k < 2; k++) model_step(k, rs, rd, s, id);
      @(posedge clk);
      #2;
   endtask

   // Output monitor: every DUT write pops one scoreboard entry
   logic mon_en = 1'b0;
   int   wcnt1 = 0;
   int   wcnt4 = 0;
   always @(posedge clk) begin
      logic [16:0] e;
      #1;
      if (mon_en) begin
         if (we1) begin
            if (sb1.size() == 0) chk_val("d1_unexpected_write", 32'(we1), 32'd0);
            else begin e = sb1.pop_front(); chk_val("d1_write", 32'({wa1, ws1}), 32'(e)); wcnt1++; end
         end
         chk_val("d1_missing_write", 32'(sb1.size()), 32'd0);
         sb1.delete();
         chk_val("d1_read_index", 32'(ri1), 32'(m_ri[0]));
         if (we4) begin
            if (sb4.size() == 0) chk_val("d4_unexpected_write", 32'(we4), 32'd0);
            else begin e = sb4.pop_front(); chk_val("d4_write", 32'({wa4, ws4}), 32'(e)); wcnt4++; end
         end
         chk_val("d4_missing_write", 32'(sb4.size()), 32'd0);
         sb4.delete();
         chk_val("d4_read_index", 32'(ri4), 32'(m_ri[1]));
      end
   end

   initial begin
      int snap1, snap4;
      tick(1'b1, 1'b0, 16'd0, 1'b0);
      tick(1'b1, 1'b0, 16'd0, 1'b0);
      mon_en = 1'b1;
      chk_val("rst_we",    32'(we1), 32'd0);
      chk_val("rst_addr",  32'(wa1), 32'h100);
      chk_val("rst_data",  32'(ws1), 32'd0);
      chk_val("rst_ri",    32'(ri1), 32'd0);
      chk_val("rst_addr4", 32'(wa4), 32'h100);

      tick(1'b0, 1'b0, 16'd0, 1'b0);
      tick(1'b0, 1'b1, 16'hFF9C, 1'b0);
      chk_val("t1_no_write_neg", 32'(we1), 32'd0);
      tick(1'b0, 1'b1, 16'd50, 1'b0);
      chk_val("t1_trig_we",   32'(we1), 32'd1);
      chk_val("t1_trig_addr", 32'(wa1), 32'h100);
      chk_val("t1_trig_data", 32'(ws1), 32'h7F);
      tick(1'b0, 1'b0, 16'd0, 1'b0);
      chk_val("t1_we_one_cycle", 32'(we1), 32'd0);

      for (int i = 0; i < 255; i++) tick(1'b0, 1'b1, 16'h7FFF, 1'b0);
      chk_val("t2_last_addr", 32'(wa1), 32'h1FF);
      chk_val("t2_last_data", 32'(ws1), 32'h00);
      tick(1'b0, 1'b1, 16'h7FFF, 1'b0);
      chk_val("t2_257th_no_write", 32'(we1), 32'd0);
      chk_val("t2_ri_still0",      32'(ri1), 32'd0);

      tick(1'b0, 1'b0, 16'd0, 1'b1);
      chk_val("t3_ri_swapped", 32'(ri1), 32'd1);
      chk_val("t3_d4_no_swap", 32'(ri4), 32'd0);
      tick(1'b0, 1'b1, 16'hFFFB, 1'b0);
      tick(1'b0, 1'b1, 16'd5, 1'b0);
      chk_val("t3_trig_addr", 32'(wa1), 32'h000);
      chk_val("t3_trig_we",   32'(we1), 32'd1);

      for (int i = 0; i < 99; i++) tick(1'b0, 1'b1, 16'd1000, 1'b0);
      tick(1'b1, 1'b0, 16'd0, 1'b0);
      chk_val("t6_ri_cleared", 32'(ri1), 32'd0);
      chk_val("t6_we_low",     32'(we1), 32'd0);
      chk_val("t6_addr_reset", 32'(wa1), 32'h100);

      snap1 = wcnt1; snap4 = wcnt4;
      for (int i = 0; i < 1023; i++) tick(1'b0, 1'b1, 16'd1000, 1'b0);
      chk_val("t4_no_early_write1", 32'(wcnt1 - snap1), 32'd0);
      chk_val("t4_no_early_write4", 32'(wcnt4 - snap4), 32'd0);
      tick(1'b0, 1'b1, 16'd1000, 1'b0);
      chk_val("t4_forced_we",   32'(we1), 32'd1);
      chk_val("t4_forced_addr", 32'(wa1), 32'h100);
      chk_val("t4_forced_data", 32'(ws1), 32'h7C);
      chk_val("t4_forced_we4",  32'(we4), 32'd1);

      snap4 = wcnt4;
      for (int i = 0; i < 1020; i++) tick(1'b0, 1'b1, 16'(($urandom_range(0, 32767))), 1'b0);
      chk_val("t5_decim_writes", 32'(wcnt4 - snap4), 32'd255);
      chk_val("t5_last_addr4",   32'(wa4), 32'h1FF);
      tick(1'b0, 1'b1, 16'h1234, 1'b0);
      chk_val("t5_wait_no_write4", 32'(we4), 32'd0);

      for (int i = 0; i < 4000; i++) begin
         tick(($urandom_range(0, 299) == 0), ($urandom_range(0, 1) == 1),
              16'($urandom), ($urandom_range(0, 9) == 0));
      end
      tick(1'b0, 1'b0, 16'd0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
